// File: rtl/eeprom_loader.sv
// eeprom_loader: boot-time copier that reads BYTE_COUNT bytes from the SPI
// eeprom reader, packs them little-endian into 32-bit words and writes each
// word to RAM starting at BASE_ADDRESS, then raises done.
// Ports:
//   clk, reset        - CPU clock, synchronous active-high reset
//   start             - one-cycle copy request, honoured only when idle/done
//   busy, done        - copy in progress / copy finished (held until restart)
//   eeprom_address    - byte address presented to the eeprom reader
//   eeprom_strobe     - read request to the eeprom reader
//   eeprom_ready      - eeprom idle / data-valid flag
//   eeprom_data_in    - byte returned by the eeprom reader
//   mem_address       - memory_bus byte address of the word being written
//   mem_write         - memory_bus write data
//   mem_write_mask    - active-low byte mask (0 = lane written)
//   mem_bus_enable    - memory_bus request
//   mem_write_enable  - write qualifier, always equal to mem_bus_enable
//   mem_data_ready    - memory_bus completion
module eeprom_loader #(
    parameter int          BYTE_COUNT   = 512,
    parameter logic [15:0] BASE_ADDRESS = 16'hc000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [10:0] eeprom_address,
    output logic        eeprom_strobe,
    input  logic        eeprom_ready,
    input  logic [7:0]  eeprom_data_in,
    output logic [15:0] mem_address,
    output logic [31:0] mem_write,
    output logic [3:0]  mem_write_mask,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    input  logic        mem_data_ready
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EE_REQ  = 3'd1;
    localparam logic [2:0] EE_ACK  = 3'd2;
    localparam logic [2:0] EE_WAIT = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_WAIT = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]  state;
    logic [11:0] count;
    logic [31:0] buffer;
    logic [11:0] count_next;
    logic [11:0] word_offset;
    logic [2:0]  lanes;

    assign count_next  = count + 12'd1;
    // Byte offset of the word holding the most recently loaded byte.
    assign word_offset = (count - 12'd1) & ~12'd3;
    // Number of loaded lanes in the current word (0 in the low bits means 4).
    assign lanes       = {count[1:0] == 2'd0, count[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            buffer           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            eeprom_address   <= '0;
            eeprom_strobe    <= 1'b0;
            mem_address      <= '0;
            mem_write        <= '0;
            mem_write_mask   <= 4'hf;
            mem_bus_enable   <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count  <= '0;
                        buffer <= '0;
                        done   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= EE_REQ;
                    end
                end
                EE_REQ: begin
                    eeprom_address <= count[10:0];
                    eeprom_strobe  <= 1'b1;
                    state          <= EE_ACK;
                end
                EE_ACK: begin
                    // Ready low means the reader accepted the request.
                    if (!eeprom_ready) begin
                        eeprom_strobe <= 1'b0;
                        state         <= EE_WAIT;
                    end
                end
                EE_WAIT: begin
                    if (eeprom_ready) begin
                        buffer[8*count[1:0] +: 8] <= eeprom_data_in;
                        count <= count_next;
                        state <= (count[1:0] == 2'd3 || count_next == 12'(BYTE_COUNT)) ? WR_REQ : EE_REQ;
                    end
                end
                WR_REQ: begin
                    mem_address      <= BASE_ADDRESS + {4'd0, word_offset};
                    mem_write        <= buffer;
                    mem_write_mask   <= 4'hf << lanes;
                    mem_bus_enable   <= 1'b1;
                    mem_write_enable <= 1'b1;
                    state            <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (mem_data_ready) begin
                        mem_bus_enable   <= 1'b0;
                        mem_write_enable <= 1'b0;
                        mem_write_mask   <= 4'hf;
                        buffer           <= '0;
                        if (count == 12'(BYTE_COUNT)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= EE_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eeprom_loader.sv
// tb_eeprom_loader: self-checking bench for eeprom_loader with behavioural
// eeprom and memory_bus models and a word-level reference of the copy.
module tb_eeprom_loader;
    localparam int          BC   = 6;
    localparam logic [15:0] BASE = 16'hc000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [10:0] eeprom_address;
    logic        eeprom_strobe;
    logic        eeprom_ready;
    logic [7:0]  eeprom_data_in;
    logic [15:0] mem_address;
    logic [31:0] mem_write;
    logic [3:0]  mem_write_mask;
    logic        mem_bus_enable;
    logic        mem_write_enable;
    logic        mem_data_ready;

    always #5 clk = ~clk;

    eeprom_loader #(.BYTE_COUNT(BC), .BASE_ADDRESS(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .eeprom_address(eeprom_address),
        .eeprom_strobe(eeprom_strobe),
        .eeprom_ready(eeprom_ready),
        .eeprom_data_in(eeprom_data_in),
        .mem_address(mem_address),
        .mem_write(mem_write),
        .mem_write_mask(mem_write_mask),
        .mem_bus_enable(mem_bus_enable),
        .mem_write_enable(mem_write_enable),
        .mem_data_ready(mem_data_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [BC];
    int  ack_dly = 0, data_dly = 0, stall_dly = 0;
    int  sc = 0, dc = 0, mc = 0, hi = 0;
    bit  pend = 1'b0;
    logic strobe_q = 1'b0;
    logic [7:0] rom_byte;

    logic [15:0] wa [$];
    logic [31:0] wd [$];
    logic [3:0]  wm [$];
    logic [10:0] ea [$];
    logic [15:0] hold_a;
    logic [31:0] hold_d;
    logic [3:0]  hold_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // eeprom model: ready stays high for ack_dly strobe cycles, then drops;
    // after the strobe falls, data becomes valid data_dly cycles later.
    // While ready is low the data bus carries a wrong byte.
    assign rom_byte       = (eeprom_address < 11'(BC)) ? rom[eeprom_address] : 8'h00;
    assign eeprom_ready   = eeprom_strobe ? (sc < ack_dly) : (pend ? (dc >= data_dly) : 1'b1);
    assign eeprom_data_in = eeprom_ready ? rom_byte : ~rom_byte;
    // memory model: completion after stall_dly enabled cycles
    assign mem_data_ready = mem_bus_enable && (mc >= stall_dly);

    always @(posedge clk) begin
        sc <= eeprom_strobe ? sc + 1 : 0;
        if (reset) pend <= 1'b0;
        else if (eeprom_strobe && !eeprom_ready) begin
            pend <= 1'b1;
            dc   <= 0;
        end else if (pend && !eeprom_strobe) begin
            if (eeprom_ready) pend <= 1'b0;
            else dc <= dc + 1;
        end
        if (eeprom_strobe && !strobe_q) ea.push_back(eeprom_address);
        strobe_q <= eeprom_strobe;
        if (mem_bus_enable && mem_data_ready) begin
            wa.push_back(mem_address);
            wd.push_back(mem_write);
            wm.push_back(mem_write_mask);
            mc <= 0;
        end else if (mem_bus_enable) mc <= mc + 1;
    end

    always @(negedge clk) begin
        if (mem_bus_enable) begin
            chk("we_eq_en", mem_write_enable, 1'b1);
            if (mc == 0) begin
                hold_a = mem_address;
                hold_d = mem_write;
                hold_m = mem_write_mask;
            end else begin
                chk("stall_addr", mem_address, hold_a);
                chk("stall_data", mem_write, hold_d);
                chk("stall_mask", mem_write_mask, hold_m);
                chk("stall_strobe", eeprom_strobe, 1'b0);
            end
        end
        if (eeprom_strobe) hi++;
        else if (hi > 0) begin
            chk("strobe_len", hi, ack_dly + 1);
            hi = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_strobe"}, eeprom_strobe, 1'b0);
        chk({tag, "_eaddr"}, eeprom_address, 11'd0);
        chk({tag, "_en"}, mem_bus_enable, 1'b0);
        chk({tag, "_we"}, mem_write_enable, 1'b0);
        chk({tag, "_maddr"}, mem_address, 16'd0);
        chk({tag, "_mdata"}, mem_write, 32'd0);
        chk({tag, "_mask"}, mem_write_mask, 4'hf);
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < BC; i++) rom[i] = 8'($urandom);
    endtask

    // Reference: word w covers bytes 4w..4w+3 that exist; missing lanes are
    // zero in the data and masked (1) in the mask.
    task automatic compare_writes();
        int nw;
        nw = (BC + 3) / 4;
        chk("write_count", wa.size(), nw);
        for (int w = 0; w < nw && w < wa.size(); w++) begin
            logic [31:0] d;
            logic [3:0]  m;
            d = 0;
            m = 4'hf;
            for (int l = 0; l < 4; l++)
                if (4 * w + l < BC) begin
                    d = d + (32'(rom[4 * w + l]) << (8 * l));
                    m[l] = 1'b0;
                end
            chk("wr_addr", wa[w], BASE + 16'(4 * w));
            chk("wr_data", wd[w], d);
            chk("wr_mask", wm[w], m);
        end
        chk("ee_count", ea.size(), BC);
        for (int i = 0; i < BC && i < ea.size(); i++) chk("ee_addr", ea[i], i);
    endtask

    task automatic run_copy(input int pulse_at, input bit chk_lat);
        int  cyc;
        logic prev_busy;
        wa.delete(); wd.delete(); wm.delete(); ea.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        prev_busy = busy;
        chk("busy_after_start", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
        while (!done && cyc < 5000) begin
            prev_busy = busy;
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        chk("done_reached", done, 1'b1);
        chk("busy_before_done", prev_busy, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        if (chk_lat) chk("latency", cyc, BC * 3 + ((BC + 3) / 4) * 2 + 1);
        compare_writes();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("init");
        reset = 1'b0;

        randomize_rom();
        run_copy(0, 1'b1);

        randomize_rom();
        stall_dly = 10;
        run_copy(0, 1'b0);
        stall_dly = 0;

        randomize_rom();
        run_copy(7, 1'b1);
        run_copy(0, 1'b1);

        randomize_rom();
        data_dly = 3;
        wa.delete(); wd.delete(); wm.delete(); ea.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(eeprom_address == 11'd2 && !eeprom_strobe && busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte2_wait", n < 200, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        chk("midreset_no_write", wa.size(), 0);
        reset = 1'b0;
        data_dly = 0;
        run_copy(0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            randomize_rom();
            ack_dly   = $urandom_range(0, 3);
            data_dly  = $urandom_range(0, 3);
            stall_dly = $urandom_range(0, 3);
            run_copy(0, 1'b0);
        end

        randomize_rom();
        ack_dly = 5;
        data_dly = 40;
        stall_dly = 0;
        run_copy(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
